// File: rtl/pipe_alu_pkg.sv
// Shared types for the Decode->Execute ALU control path: ALU op codes,
// data-processing cmd encodings, flag-write masks and the Execute control word.
package pipe_alu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_ORR = 4'b0011,
        ALU_BIC = 4'b0100,
        ALU_EOR = 4'b0101,
        ALU_MOV = 4'b0110,
        ALU_MVN = 4'b0111,
        ALU_MUL = 4'b1000
    } alu_ctrl_e;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_TEQ = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_BIC = 4'b1110;
    localparam logic [3:0] CMD_MVN = 4'b1111;

    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_NZCV = 2'b11;

    typedef struct packed {
        alu_ctrl_e  alu_ctrl;
        logic [1:0] flag_w;
        logic       no_write;
        logic       illegal;
        logic       valid;
    } e_ctrl_t;

endpackage

// File: rtl/pipe_alu_func_decode.sv
// Combinational data-processing decoder: cmd/S/MUL -> Execute control word.
module pipe_alu_func_decode
    import pipe_alu_pkg::*;
(
    input  logic       alu_op,
    input  logic [4:0] funct,
    input  logic       mul,
    input  logic       valid,
    output e_ctrl_t    ctrl
);

    logic [3:0] cmd;
    logic       s;

    assign cmd = funct[4:1];
    assign s   = funct[0];

    always_comb begin
        ctrl          = '0;
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.valid    = valid;
        if (alu_op) begin
            if (mul) begin
                ctrl.alu_ctrl = ALU_MUL;
                ctrl.flag_w   = {s, 1'b0};
            end else begin
                case (cmd)
                    CMD_ADD: begin ctrl.alu_ctrl = ALU_ADD; ctrl.flag_w = {s, s};    end
                    CMD_SUB: begin ctrl.alu_ctrl = ALU_SUB; ctrl.flag_w = {s, s};    end
                    CMD_AND: begin ctrl.alu_ctrl = ALU_AND; ctrl.flag_w = {s, 1'b0}; end
                    CMD_ORR: begin ctrl.alu_ctrl = ALU_ORR; ctrl.flag_w = {s, 1'b0}; end
                    CMD_BIC: begin ctrl.alu_ctrl = ALU_BIC; ctrl.flag_w = {s, 1'b0}; end
                    CMD_EOR: begin ctrl.alu_ctrl = ALU_EOR; ctrl.flag_w = {s, 1'b0}; end
                    CMD_MOV: begin ctrl.alu_ctrl = ALU_MOV; ctrl.flag_w = {s, 1'b0}; end
                    CMD_MVN: begin ctrl.alu_ctrl = ALU_MVN; ctrl.flag_w = {s, 1'b0}; end
                    // compare forms always write flags and never the register file
                    CMD_CMP: begin ctrl.alu_ctrl = ALU_SUB; ctrl.flag_w = FLAGW_NZCV; ctrl.no_write = 1'b1; end
                    CMD_CMN: begin ctrl.alu_ctrl = ALU_ADD; ctrl.flag_w = FLAGW_NZCV; ctrl.no_write = 1'b1; end
                    CMD_TST: begin ctrl.alu_ctrl = ALU_AND; ctrl.flag_w = FLAGW_NZ;   ctrl.no_write = 1'b1; end
                    CMD_TEQ: begin ctrl.alu_ctrl = ALU_EOR; ctrl.flag_w = FLAGW_NZ;   ctrl.no_write = 1'b1; end
                    default: begin
                        ctrl.flag_w   = FLAGW_NONE;
                        ctrl.no_write = 1'b1;
                        ctrl.illegal  = 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/pipe_alu_decode_stage.sv
// Decode-stage ALU decoder feeding the Execute control register, with a
// fixed-latency MUL occupancy FSM that holds Execute and reports busy.
module pipe_alu_decode_stage
    import pipe_alu_pkg::*;
#(
    parameter int ALUCTRL_W  = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ALUOpD,
    input  logic [4:0]           FunctD,
    input  logic                 MulD,
    input  logic                 ValidD,
    input  logic                 StallE,
    input  logic                 FlushE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [1:0]           FlagWE,
    output logic                 NoWriteE,
    output logic                 IllegalE,
    output logic                 ValidE,
    output logic                 MulBusy,
    output logic                 MulDoneE
);

    localparam int              CNT_W    = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit              MULTI    = (MUL_CYCLES > 1);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;

    e_ctrl_t          dec_d;
    e_ctrl_t          ctrl_e;
    logic             state;
    logic [CNT_W-1:0] cnt;
    logic             last_cycle;
    logic             hold;
    logic             load_mul;

    pipe_alu_func_decode u_dec (
        .alu_op (ALUOpD),
        .funct  (FunctD),
        .mul    (MulD),
        .valid  (ValidD),
        .ctrl   (dec_d)
    );

    // The final MUL cycle releases Execute so the next op loads on the BUSY exit edge.
    assign last_cycle = (state == S_BUSY) && (cnt == CNT_ONE);
    assign hold       = StallE | ((state == S_BUSY) & ~last_cycle);
    assign load_mul   = MULTI & ~hold & dec_d.valid & (dec_d.alu_ctrl == ALU_MUL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       ctrl_e <= '0;
        else if (FlushE) ctrl_e <= '0;
        else if (!hold)  ctrl_e <= dec_d;
    end

    // Counter runs regardless of StallE so MUL latency stays fixed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (FlushE) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (load_mul) begin
            state <= S_BUSY;
            cnt   <= CNT_LOAD;
        end else if (state == S_BUSY) begin
            if (last_cycle) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    assign ALUControlE = ALUCTRL_W'(ctrl_e.alu_ctrl);
    assign FlagWE      = ctrl_e.flag_w;
    assign NoWriteE    = ctrl_e.no_write;
    assign IllegalE    = ctrl_e.illegal;
    assign ValidE      = ctrl_e.valid;
    assign MulBusy     = (state == S_BUSY);
    assign MulDoneE    = ctrl_e.valid & (ctrl_e.alu_ctrl == ALU_MUL) & (MULTI ? last_cycle : 1'b1);

endmodule

// File: tb/tb_pipe_alu_decode_stage.sv
// Self-checking bench: directed MUL/flush/reset scenarios plus a randomized
// stream, all checked against a cycle-level occupancy model of the stage.
module tb_pipe_alu_decode_stage;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       ALUOpD, MulD, ValidD, StallE, FlushE;
    logic [4:0] FunctD;
    logic [3:0] ALUControlE;
    logic [1:0] FlagWE;
    logic       NoWriteE, IllegalE, ValidE, MulBusy, MulDoneE;

    int vectors = 0;
    int errors  = 0;

    pipe_alu_decode_stage #(.ALUCTRL_W(4), .MUL_CYCLES(N)) dut (
        .clk(clk), .reset(reset), .ALUOpD(ALUOpD), .FunctD(FunctD), .MulD(MulD),
        .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .ALUControlE(ALUControlE),
        .FlagWE(FlagWE), .NoWriteE(NoWriteE), .IllegalE(IllegalE), .ValidE(ValidE),
        .MulBusy(MulBusy), .MulDoneE(MulDoneE)
    );

    always #5 clk = ~clk;

    wire [10:0] dut_vec = {ALUControlE, FlagWE, NoWriteE, IllegalE, ValidE, MulBusy, MulDoneE};

    // cmd -> op and flag class, straight from the instruction table
    // class: 0 logical, 1 arithmetic, 2 compare NZCV, 3 compare NZ, 4 illegal
    logic [3:0] op_of   [16];
    int         kind_of [16];

    // model: Execute contents plus number of cycles the resident MUL still occupies
    logic [3:0] m_alu;
    logic [1:0] m_fw;
    logic       m_nw, m_il, m_v;
    int         occ;

    function automatic logic [7:0] ref_dec(input logic aop, input logic [4:0] f, input logic mul);
        logic [3:0] c = f[4:1];
        logic       s = f[0];
        if (!aop) return 8'b0000_00_0_0;
        if (mul)  return {4'b1000, s, 1'b0, 2'b00};
        case (kind_of[c])
            0:       return {op_of[c], s, 1'b0, 2'b00};
            1:       return {op_of[c], s, s, 2'b00};
            2:       return {op_of[c], 2'b11, 2'b10};
            3:       return {op_of[c], 2'b10, 2'b10};
            default: return {4'b0000, 2'b00, 2'b11};
        endcase
    endfunction

    function automatic logic [10:0] exp_vec();
        return {m_alu, m_fw, m_nw, m_il, m_v, occ > 0, m_v && (m_alu == 4'd8) && (occ == 1)};
    endfunction

    task automatic model_clear();
        {m_alu, m_fw, m_nw, m_il, m_v} = '0;
        occ = 0;
    endtask

    task automatic drive(input logic aop, input logic [4:0] f, input logic mul, input logic v,
                         input logic st, input logic fl);
        ALUOpD = aop; FunctD = f; MulD = mul; ValidD = v; StallE = st; FlushE = fl;
    endtask

    // advance the model across the coming edge, then step the DUT and settle
    task automatic tick();
        logic [7:0] d;
        bit         blocked;
        int         occ_n;
        d       = ref_dec(ALUOpD, FunctD, MulD);
        blocked = StallE || (occ > 1);
        occ_n   = (occ > 0) ? occ - 1 : 0;
        if (FlushE) begin
            model_clear();
        end else begin
            if (!blocked) begin
                {m_alu, m_fw, m_nw, m_il} = d;
                m_v = ValidD;
                if (ValidD && d[7:4] == 4'd8) occ_n = N - 1;
            end
            occ = occ_n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 5'b01001, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (dut_vec !== 11'd0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", dut_vec, 11'd0);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_decode_sweep();
        for (int f = 0; f < 32; f++) begin
            drive(1'b1, 5'(f), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL sweep_f%0d got=%b exp=%b", f, dut_vec, exp_vec());
            end
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 5'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL aluop0_%0d got=%b exp=%b", i, dut_vec, exp_vec());
            end
        end
        drive(1'b1, 5'b10101, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if (dut_vec !== 11'b0001_11_1_0_1_0_0) begin
            errors++;
            $display("FAIL cmp_decode got=%b exp=%b", dut_vec, 11'b0001_11_1_0_1_0_0);
        end
        drive(1'b0, 5'b10101, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if (dut_vec !== 11'b0000_00_0_0_1_0_0) begin
            errors++;
            $display("FAIL aluop0_cmp got=%b exp=%b", dut_vec, 11'b0000_00_0_0_1_0_0);
        end
        drive(1'b1, 5'b01010, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if (dut_vec !== 11'b0000_00_1_1_1_0_0) begin
            errors++;
            $display("FAIL illegal_0101 got=%b exp=%b", dut_vec, 11'b0000_00_1_1_1_0_0);
        end
        // invalid MUL loads but never occupies Execute
        drive(1'b1, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (MulBusy !== 1'b0 || ValidE !== 1'b0 || ALUControlE !== 4'd8) begin
            errors++;
            $display("FAIL invalid_mul busy=%b valid=%b alu=%h exp busy=0 valid=0 alu=8",
                     MulBusy, ValidE, ALUControlE);
        end
    endtask

    task automatic test_mul();
        drive(1'b1, 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if (dut_vec !== 11'b1000_10_0_0_1_1_0) begin
            errors++;
            $display("FAIL mul_cycle_k got=%b exp=%b", dut_vec, 11'b1000_10_0_0_1_1_0);
        end
        drive(1'b1, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if (dut_vec !== 11'b1000_10_0_0_1_1_1) begin
            errors++;
            $display("FAIL mul_cycle_k1 got=%b exp=%b", dut_vec, 11'b1000_10_0_0_1_1_1);
        end
        tick();
        vectors++;
        if (dut_vec !== 11'b0000_00_0_0_1_0_0) begin
            errors++;
            $display("FAIL add_after_mul got=%b exp=%b", dut_vec, 11'b0000_00_0_0_1_0_0);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0, done_cnt = 0;
        for (int t = 0; t < 7; t++) begin
            if (t < 3) drive(1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
            else       drive(1'b1, 5'b01001, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_t%0d got=%b exp=%b", t, dut_vec, exp_vec());
            end
            busy_cnt += int'(MulBusy);
            done_cnt += int'(MulDoneE);
        end
        vectors++;
        if (busy_cnt != 4 || done_cnt != 2) begin
            errors++;
            $display("FAIL b2b_counts busy=%0d done=%0d exp busy=4 done=2", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'b01000, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        vectors++;
        if (dut_vec !== 11'd0) begin
            errors++;
            $display("FAIL flush_bubble got=%b exp=%b", dut_vec, 11'd0);
        end
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            vectors++;
            if (dut_vec !== exp_vec() || MulDoneE !== 1'b0) begin
                errors++;
                $display("FAIL flush_after_t%0d got=%b exp=%b", t, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_stall_mul();
        drive(1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, 5'b00101, 1'b0, 1'b1, (t < 2), 1'b0);
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL stall_mul_t%0d got=%b exp=%b", t, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int done_at = -1;
        drive(1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (dut_vec !== 11'd0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", dut_vec, 11'd0);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        tick();
        drive(1'b1, 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 8 && done_at < 0; t++) begin
            if (MulDoneE === 1'b1) done_at = t;
            else tick();
        end
        vectors++;
        if (done_at != N - 1) begin
            errors++;
            $display("FAIL post_reset_mul done_cycle=%0d exp=%0d", done_at, N - 1);
        end
        tick();
        vectors++;
        if (dut_vec !== exp_vec() || ALUControlE !== 4'd0 || MulBusy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_next got=%b exp=%b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 9) == 0));
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_t%0d got=%b exp=%b", t, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        op_of = '{4'd2, 4'd5, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                  4'd2, 4'd5, 4'd1, 4'd0, 4'd3, 4'd6, 4'd4, 4'd7};
        kind_of = '{0, 0, 1, 4, 1, 4, 4, 4, 3, 3, 2, 2, 0, 0, 0, 0};
        model_clear();
        reset = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_decode_sweep();
        test_mul();
        test_back_to_back();
        test_flush();
        test_stall_mul();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
